// File: rtl/regfile_pkg.sv
// Shared constants, port-slice helper and pending-counter vector type for regfile_sb.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned PW_DEF    = 2;

  // Pending-write counters of all registers at default sizing.
  typedef logic [NREGS_DEF-1:0][PW_DEF-1:0] pendVec_t;

  // Low bit of port idx inside a flattened multi-port vector of w-bit slices.
  function automatic int unsigned sliceLo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, write and issue ports of regfile_sb; master = pipeline side, slave = register file.
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]      wr_retire;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                sb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_retire, iss_valid, iss_rd,
    input  rd_data, rd_busy, iss_ready, sb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_retire, iss_valid, iss_rd,
    output rd_data, rd_busy, iss_ready, sb_err
  );

endinterface

// File: rtl/regfile_sb_cnt.sv
// One register's pending-write counter: +inc, -decCnt per edge, clamps at 0 on underflow.
module regfile_sb_cnt import regfile_pkg::*; #(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [1:0]    decCnt,
  output logic [PW-1:0] cnt,
  output logic [PW-1:0] cntNext_c,
  output logic          underflow_c
);

  localparam int unsigned SW = PW + 2;
  localparam logic [SW-1:0] MAXV = SW'((1 << PW) - 1);

  logic [SW-1:0] sum;

  // Post-edge count; saturates at the counter limit, floors at zero with a flag.
  always_comb begin
    sum         = SW'(cnt) + SW'(inc);
    underflow_c = 1'b0;
    cntNext_c   = cnt;
    if (SW'(decCnt) > sum) begin
      underflow_c = 1'b1;
      cntNext_c   = '0;
    end else if ((sum - SW'(decCnt)) > MAXV) begin
      cntNext_c = MAXV[PW-1:0];
    end else begin
      cntNext_c = PW'(sum - SW'(decCnt));
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cntNext_c;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register pending-write scoreboard.
// x0 reads zero and is never busy. Define REGFILE_BYPASS_EN to forward
// same-cycle writes (data and post-edge busy) onto matching read ports.
module regfile_sb import regfile_pkg::*; #(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  parameter int unsigned PW    = PW_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [PW-1:0] PEND_MAX = '1;

  logic [XLEN-1:0]            regs [NREGS];
  logic [NREGS-1:0][PW-1:0]   pend;
  logic [NREGS-1:0][PW-1:0]   pendNext;
  logic [NREGS-1:0]           underflow;
  logic                       issFire;
  logic [AW-1:0]              rdA;
  logic [NRD*XLEN-1:0]        rdDataFlat;
  logic [NRD-1:0]             rdBusyVec;
  logic                       sbErr;

  assign pend[0]      = '0;
  assign pendNext[0]  = '0;
  assign underflow[0] = 1'b0;

  // Issue is accepted unless the destination counter is full; x0 always accepts.
  assign bus.iss_ready = (bus.iss_rd == '0) || (pend[bus.iss_rd] != PEND_MAX);
  assign issFire       = bus.iss_valid & bus.iss_ready;

  for (genvar r = 1; r < NREGS; r++) begin : gCnt
    logic       inc;
    logic [1:0] decCnt;

    assign inc = issFire && (bus.iss_rd == AW'(r));

    // Count retiring writes that target this register this cycle.
    always_comb begin
      decCnt = '0;
      for (int unsigned k = 0; k < NWR; k++) begin
        if (bus.wr_en[k] && bus.wr_retire[k] &&
            (bus.wr_addr[sliceLo(k, AW) +: AW] == AW'(r))) begin
          decCnt = decCnt + 2'd1;
        end
      end
    end

    regfile_sb_cnt #(.PW(PW)) uCnt (
      .clk         (clk),
      .rst         (rst),
      .inc         (inc),
      .decCnt      (decCnt),
      .cnt         (pend[r]),
      .cntNext_c   (pendNext[r]),
      .underflow_c (underflow[r])
    );
  end

  // Storage; later ports overwrite earlier ones so port 1 wins on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (bus.wr_en[k] && (bus.wr_addr[sliceLo(k, AW) +: AW] != '0)) begin
          regs[bus.wr_addr[sliceLo(k, AW) +: AW]] <= bus.wr_data[sliceLo(k, XLEN) +: XLEN];
        end
      end
    end
  end

  // Sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            sbErr <= 1'b0;
    else if (|underflow) sbErr <= 1'b1;
  end

`ifdef REGFILE_BYPASS_EN
  logic [AW-1:0] wrA;
`else
  logic unusedPendNext;
  assign unusedPendNext = ^pendNext;
`endif

  // Combinational read ports: stored data and busy, optionally forwarded.
  always_comb begin
    rdDataFlat = '0;
    rdBusyVec  = '0;
    rdA        = '0;
`ifdef REGFILE_BYPASS_EN
    wrA        = '0;
`endif
    for (int unsigned i = 0; i < NRD; i++) begin
      rdA = bus.rd_addr[sliceLo(i, AW) +: AW];
      if (rdA != '0) begin
        rdDataFlat[sliceLo(i, XLEN) +: XLEN] = regs[rdA];
        rdBusyVec[i] = (pend[rdA] != '0);
      end
`ifdef REGFILE_BYPASS_EN
      if (!rst) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          wrA = bus.wr_addr[sliceLo(k, AW) +: AW];
          if (bus.wr_en[k] && (wrA != '0) && (wrA == rdA)) begin
            rdDataFlat[sliceLo(i, XLEN) +: XLEN] = bus.wr_data[sliceLo(k, XLEN) +: XLEN];
            rdBusyVec[i] = (pendNext[rdA] != '0);
          end
        end
      end
`endif
    end
  end

  assign bus.rd_data = rdDataFlat;
  assign bus.rd_busy = rdBusyVec;
  assign bus.sb_err  = sbErr;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic vs. a queue/array model.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int PW    = 2;
  localparam int AW    = 5;
  localparam int MAXP  = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0] mRegs [NREGS];
  int              mPend [NREGS];
  bit              mErr;

  function automatic int ra(int i);  return int'(bus.rd_addr[i*AW +: AW]); endfunction
  function automatic int wa(int k);  return int'(bus.wr_addr[k*AW +: AW]); endfunction
  function automatic logic [XLEN-1:0] wd(int k); return bus.wr_data[k*XLEN +: XLEN]; endfunction

  function automatic void resetModel();
    for (int r = 0; r < NREGS; r++) begin mRegs[r] = '0; mPend[r] = 0; end
    mErr = 1'b0;
  endfunction

  function automatic bit expReady();
    return (bus.iss_rd == '0) || (mPend[bus.iss_rd] != MAXP);
  endfunction

  // Outstanding count of register r after the coming edge; -1 means underflow.
  function automatic int nextPend(int r);
    int inc;
    int dec;
    int s;
    if (r == 0) return 0;
    inc = (bus.iss_valid && expReady() && int'(bus.iss_rd) == r) ? 1 : 0;
    dec = 0;
    for (int k = 0; k < NWR; k++)
      if (bus.wr_en[k] && bus.wr_retire[k] && wa(k) == r) dec++;
    s = mPend[r] + inc - dec;
    return (s < 0) ? -1 : s;
  endfunction

  function automatic void modelEdge();
    int np [NREGS];
    for (int r = 0; r < NREGS; r++) np[r] = nextPend(r);
    for (int r = 0; r < NREGS; r++) begin
      if (np[r] < 0) begin mPend[r] = 0; mErr = 1'b1; end
      else mPend[r] = np[r];
    end
    for (int k = 0; k < NWR; k++)
      if (bus.wr_en[k] && wa(k) != 0) mRegs[wa(k)] = wd(k);
  endfunction

  function automatic logic [XLEN-1:0] expData(int i);
    logic [XLEN-1:0] d;
    int a;
    a = ra(i);
    d = (a == 0) ? '0 : mRegs[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst)
      for (int k = 0; k < NWR; k++)
        if (bus.wr_en[k] && wa(k) != 0 && wa(k) == a) d = wd(k);
`endif
    return d;
  endfunction

  function automatic bit expBusy(int i);
    bit b;
    int a;
    a = ra(i);
    b = (a != 0) && (mPend[a] != 0);
`ifdef REGFILE_BYPASS_EN
    if (!rst)
      for (int k = 0; k < NWR; k++)
        if (bus.wr_en[k] && wa(k) != 0 && wa(k) == a) b = (nextPend(a) > 0);
`endif
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.rd_addr   = '0;
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_retire = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic setWr(int k, int addr, logic [XLEN-1:0] data, bit retire);
    bus.wr_en[k]                = 1'b1;
    bus.wr_addr[k*AW +: AW]     = AW'(addr);
    bus.wr_data[k*XLEN +: XLEN] = data;
    bus.wr_retire[k]            = retire;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) resetModel();
    else     modelEdge();
    #1;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    doReset();
    bus.rd_addr[0 +: AW] = AW'(1);
    bus.iss_rd = AW'(5);
    #1;
    total++; if (bus.rd_data[0 +: XLEN] !== 32'h0) begin bad++; $display("FAIL reset rd_data: got %h want 0", bus.rd_data[0 +: XLEN]); end
    total++; if (bus.rd_busy !== 2'b00) begin bad++; $display("FAIL reset rd_busy: got %b want 00", bus.rd_busy); end
    total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL reset iss_ready: got %b want 1", bus.iss_ready); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL reset sb_err: got %b want 0", bus.sb_err); end
    // Make x5 busy, then assert reset in the middle of a write to it.
    bus.iss_valid = 1'b1;
    tick();
    bus.iss_valid = 1'b0;
    bus.rd_addr[0 +: AW] = AW'(5);
    #1;
    total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL pre-reset busy x5: got %b want 1", bus.rd_busy[0]); end
    setWr(0, 5, 32'hDEADBEEF, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    total++; if (bus.rd_data[0 +: XLEN] !== 32'h0) begin bad++; $display("FAIL midreset rd_data x5: got %h want 0", bus.rd_data[0 +: XLEN]); end
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL midreset busy x5: got %b want 0", bus.rd_busy[0]); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL midreset sb_err: got %b want 0", bus.sb_err); end
    tick();
    idle();
    bus.rd_addr[0 +: AW] = AW'(5);
    #1;
    rst = 1'b0;
    tick();
    total++; if (bus.rd_data[0 +: XLEN] !== 32'h0) begin bad++; $display("FAIL postreset rd_data x5: got %h want 0", bus.rd_data[0 +: XLEN]); end
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL postreset busy x5: got %b want 0", bus.rd_busy[0]); end
  endtask

  task automatic test_dual_write();
    logic [XLEN-1:0] sameCyc;
    idle();
    setWr(0, 7, 32'h11111111, 1'b0);
    setWr(1, 7, 32'h22222222, 1'b0);
    bus.rd_addr[0 +: AW] = AW'(7);
    #1;
`ifdef REGFILE_BYPASS_EN
    sameCyc = 32'h22222222;
`else
    sameCyc = 32'h0;
`endif
    total++; if (bus.rd_data[0 +: XLEN] !== sameCyc) begin bad++; $display("FAIL dual same-cycle x7: got %h want %h", bus.rd_data[0 +: XLEN], sameCyc); end
    tick();
    idle();
    bus.rd_addr[0 +: AW] = AW'(7);
    setWr(0, 0, 32'hFFFFFFFF, 1'b0);
    #1;
    total++; if (bus.rd_data[0 +: XLEN] !== 32'h22222222) begin bad++; $display("FAIL dual x7: got %h want 22222222", bus.rd_data[0 +: XLEN]); end
    total++; if (bus.rd_data[XLEN +: XLEN] !== 32'h0) begin bad++; $display("FAIL x0 during write: got %h want 0", bus.rd_data[XLEN +: XLEN]); end
    tick();
    idle();
    bus.rd_addr[0 +: AW]  = AW'(7);
    bus.rd_addr[AW +: AW] = AW'(0);
    #1;
    total++; if (bus.rd_data[XLEN +: XLEN] !== 32'h0) begin bad++; $display("FAIL x0 after write: got %h want 0", bus.rd_data[XLEN +: XLEN]); end
    total++; if (bus.rd_data[0 +: XLEN] !== 32'h22222222) begin bad++; $display("FAIL x7 hold: got %h want 22222222", bus.rd_data[0 +: XLEN]); end
  endtask

  task automatic test_saturation();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = AW'(3);
    tick(); tick(); tick();
    #1;
    total++; if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL sat ready x3: got %b want 0", bus.iss_ready); end
    tick();
    bus.iss_valid = 1'b0;
    bus.iss_rd    = AW'(4);
    #1;
    total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL sat ready x4: got %b want 1", bus.iss_ready); end
    bus.iss_rd = AW'(3);
    bus.rd_addr[0 +: AW] = AW'(3);
    #1;
    total++; if (bus.iss_ready !== 1'b0) begin bad++; $display("FAIL sat ready x3 idle: got %b want 0", bus.iss_ready); end
    for (int n = 1; n <= 3; n++) begin
      setWr(0, 3, XLEN'(32'hA0 + n), 1'b1);
      tick();
      idle();
      bus.iss_rd = AW'(3);
      bus.rd_addr[0 +: AW] = AW'(3);
      #1;
      total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL sat ready after retire %0d: got %b want 1", n, bus.iss_ready); end
      total++; if (bus.rd_busy[0] !== (n < 3)) begin bad++; $display("FAIL sat busy after retire %0d: got %b want %b", n, bus.rd_busy[0], (n < 3)); end
    end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL sat sb_err: got %b want 0", bus.sb_err); end
  endtask

  task automatic test_issue_retire();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = AW'(9);
    tick();
    setWr(0, 9, 32'h99, 1'b1);
    #1;
    total++; if (bus.iss_ready !== 1'b1) begin bad++; $display("FAIL iss+ret ready: got %b want 1", bus.iss_ready); end
    tick();
    idle();
    bus.rd_addr[0 +: AW] = AW'(9);
    #1;
    total++; if (bus.rd_busy[0] !== 1'b1) begin bad++; $display("FAIL iss+ret busy x9: got %b want 1", bus.rd_busy[0]); end
    total++; if (bus.rd_data[0 +: XLEN] !== 32'h99) begin bad++; $display("FAIL iss+ret data x9: got %h want 99", bus.rd_data[0 +: XLEN]); end
    setWr(0, 9, 32'h91, 1'b1);
    setWr(1, 9, 32'h92, 1'b1);
    tick();
    idle();
    bus.rd_addr[0 +: AW] = AW'(9);
    #1;
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL underflow busy x9: got %b want 0", bus.rd_busy[0]); end
    total++; if (bus.sb_err !== 1'b1) begin bad++; $display("FAIL underflow sb_err: got %b want 1", bus.sb_err); end
    total++; if (bus.rd_data[0 +: XLEN] !== 32'h92) begin bad++; $display("FAIL underflow data x9: got %h want 92", bus.rd_data[0 +: XLEN]); end
    tick(); tick();
    total++; if (bus.sb_err !== 1'b1) begin bad++; $display("FAIL sb_err sticky: got %b want 1", bus.sb_err); end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] expD;
    bit expB;
    doReset();
    setWr(0, 12, 32'h12345678, 1'b0);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = AW'(12);
    tick();
    idle();
    setWr(0, 12, 32'hCAFEF00D, 1'b1);
    bus.rd_addr[0 +: AW] = AW'(12);
    #1;
`ifdef REGFILE_BYPASS_EN
    expD = 32'hCAFEF00D; expB = 1'b0;
`else
    expD = 32'h12345678; expB = 1'b1;
`endif
    total++; if (bus.rd_data[0 +: XLEN] !== expD) begin bad++; $display("FAIL bypass same-cycle data: got %h want %h", bus.rd_data[0 +: XLEN], expD); end
    total++; if (bus.rd_busy[0] !== expB) begin bad++; $display("FAIL bypass same-cycle busy: got %b want %b", bus.rd_busy[0], expB); end
    tick();
    idle();
    bus.rd_addr[0 +: AW] = AW'(12);
    #1;
    total++; if (bus.rd_data[0 +: XLEN] !== 32'hCAFEF00D) begin bad++; $display("FAIL bypass next data: got %h want cafef00d", bus.rd_data[0 +: XLEN]); end
    total++; if (bus.rd_busy[0] !== 1'b0) begin bad++; $display("FAIL bypass next busy: got %b want 0", bus.rd_busy[0]); end
  endtask

  task automatic test_random();
    int a;
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      for (int i = 0; i < NRD; i++) bus.rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      bus.iss_valid = ($urandom_range(0, 2) == 0);
      bus.iss_rd    = AW'($urandom_range(0, 7));
      for (int k = 0; k < NWR; k++) begin
        if ($urandom_range(0, 9) < 6) begin
          a = $urandom_range(0, 7);
          setWr(k, a, XLEN'($urandom), (mPend[a] > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0));
        end else if ($urandom_range(0, 4) == 0) begin
          bus.wr_retire[k] = 1'b1;
          bus.wr_addr[k*AW +: AW] = AW'($urandom_range(1, 7));
        end
      end
      #1;
      for (int i = 0; i < NRD; i++) begin
        total++; if (bus.rd_data[i*XLEN +: XLEN] !== expData(i)) begin bad++; $display("FAIL rnd rd_data[%0d] cyc %0d: got %h want %h", i, cyc, bus.rd_data[i*XLEN +: XLEN], expData(i)); end
        total++; if (bus.rd_busy[i] !== expBusy(i)) begin bad++; $display("FAIL rnd rd_busy[%0d] cyc %0d: got %b want %b", i, cyc, bus.rd_busy[i], expBusy(i)); end
      end
      total++; if (bus.iss_ready !== expReady()) begin bad++; $display("FAIL rnd iss_ready cyc %0d: got %b want %b", cyc, bus.iss_ready, expReady()); end
      total++; if (bus.sb_err !== mErr) begin bad++; $display("FAIL rnd sb_err cyc %0d: got %b want %b", cyc, bus.sb_err, mErr); end
      tick();
    end
  endtask

  initial begin
    idle();
    resetModel();
    test_reset();
    test_dual_write();
    test_saturation();
    test_issue_retire();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the core's three-port register file.
- Configurable data width, register count, read-port count and write-port count (1 or 2).
- Writes on posedge clk; adds a per-register pending-write scoreboard for issue-stage hazard detection.
- Sits between decode/issue (read + issue ports) and writeback (write ports). Register 0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2, ≥4); AW = $clog2(NREGS).
- NRD, 2, number of combinational read ports (1..4).
- NWR, 2, number of write ports (1 or 2); port 1 has priority.
- PW, 2, width of each pending-write counter; max outstanding writes per register = 2^PW-1.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- rd_addr, input, NRD*AW, read addresses; port i at [i*AW +: AW].
- rd_data, output, NRD*XLEN, read data per port.
- rd_busy, output, NRD, 1 = addressed register has pending count ≠ 0.
- wr_en, input, NWR, write enables.
- wr_addr, input, NWR*AW, write addresses.
- wr_data, input, NWR*XLEN, write data.
- wr_retire, input, NWR, 1 = this write retires one scoreboard entry.
- iss_valid, input, 1, issue requests a scoreboard entry for iss_rd.
- iss_rd, input, AW, destination register of the issuing instruction.
- iss_ready, output, 1, entry can be accepted this cycle.
- sb_err, output, 1, sticky scoreboard underflow flag.

Behaviour:
- Reset (async, rst=1): all registers = 0, all pending counters = 0, sb_err = 0.
  - During reset: rd_data = 0, rd_busy = 0, iss_ready = 1 (combinational from cleared state).
  - Reset mid-operation discards any in-flight issue or write.
- Write: on posedge, if wr_en[k] and wr_addr[k] ≠ 0, then regs[wr_addr[k]] <= wr_data[k].
  - Writes to address 0 are dropped.
  - Both ports to the same nonzero address in one cycle: port 1 data is stored.
- Read: combinational. rd_data = regs[rd_addr], or 0 when rd_addr = 0.
  - Without bypass (see Optional Feature), a same-cycle write becomes visible the cycle after the edge.
- Scoreboard: one PW-bit counter pend[r] per register; pend[0] is constant 0.
- Issue handshake: iss_fire = iss_valid & iss_ready.
  - iss_ready = (iss_rd == 0) | (pend[iss_rd] != 2^PW-1), combinational.
  - iss_valid may depend on iss_ready.
  - Firing with iss_rd = 0 changes nothing.
- Per-edge counter update for register r:
  - inc = iss_fire & (iss_rd == r).
  - dec = number of k with wr_en[k] & wr_retire[k] & (wr_addr[k] == r), range 0..2.
  - pend[r] <= pend[r] + inc - dec.
  - Simultaneous inc and dec of 1 on the same register: count unchanged.
- Underflow: if dec > pend[r] + inc, pend[r] <= 0 and sb_err <= 1.
  - sb_err clears only on reset.
- wr_retire with wr_en = 0 is ignored.
- rd_busy[i] = (pend[rd_addr[i]] != 0).
  - Not bypassed: a retiring write clears busy on the next cycle.
- No internal latency beyond one edge. No stalls other than iss_ready.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose address matches an active same-cycle write (wr_en, nonzero address) returns wr_data combinationally (port 1 wins).
  - rd_busy for that port also reflects the post-edge count, i.e. it drops if this write retires the last entry and no issue to it fires.
- Undefined: reads return only stored state; forwarding is the pipeline's responsibility.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants XLEN_DEF, NREGS_DEF, PW_DEF;
  - function for port slice offsets;
  - typedef for the pending-counter vector.
- One natural sub-module: regfile_sb_cnt, a single saturating pending counter with inc, dec-count, underflow-flag outputs, instantiated NREGS-1 times via generate.
- Storage array and read muxes stay in the top.

Test Plan:
- Reset mid-write: write x5=0xDEADBEEF while asserting rst asynchronously → rd_data for x5 = 0, rd_busy = 0, sb_err = 0 immediately and after release.
- Dual-write conflict: wr_en=2'b11, both to x7, port0 0x11111111, port1 0x22222222 → x7 reads 0x22222222 next cycle; write to x0 with 0xFFFFFFFF → x0 reads 0.
- Scoreboard saturation (PW=2): issue x3 three times → pend=3, iss_ready=0 for iss_rd=3 and 1 for iss_rd=4. Retire once → iss_ready=1 next cycle, rd_busy(x3) stays 1 until third retire.
- Simultaneous issue + retire on x9 with pend=1 → pend stays 1, rd_busy stays 1. Two retiring writes to x9 with pend=1 → pend=0, sb_err=1 sticky.
- Bypass (REGFILE_BYPASS_EN): write x12=0xCAFEF00D with retire while reading x12 with pend=1 → same-cycle rd_data=0xCAFEF00D, rd_busy=0. Without macro → old value and busy=1 this cycle, new value/busy=0 next cycle.
